// File: rtl/mem_stage_ctrl.sv
// M-stage data-memory controller: one req/ack transaction per load/store, pipeline stall, lane steering.
// Optional macro ALIGN_EXC_EN raises address-error exceptions for misaligned accesses instead of issuing them.
module mem_stage_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       instr,
   input  logic              valid_M,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              bus_req,
   output logic              bus_we,
   output logic [3:0]        bus_be,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata,
   output logic              stall_M,
   output logic [31:0]       ld_data,
   output logic [1:0]        WD_M_sel,
   output logic              timeout_err,
   output logic              exc_M,
   output logic [4:0]        exc_code,
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [5:0]       opcode, funct;
   logic             is_load, is_store, memop, tmo_hit;
   logic [3:0]       be_next;
   logic [31:0]      wdata_next, ld_ext;
   logic [2:0]       ld_op;
   logic [1:0]       lane;
   logic [7:0]       byte_sel;
   logic [15:0]      half_sel;
   logic             unused_bits;

   assign opcode      = instr[31:26];
   assign funct       = instr[5:0];
   assign unused_bits = ^instr[25:6];
   assign fsm_state   = state;

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      case (opcode)
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: is_load  = 1'b1;
         6'h28, 6'h29, 6'h2B:               is_store = 1'b1;
         default: ;
      endcase
   end

`ifdef ALIGN_EXC_EN
   logic misaligned;
   assign misaligned = (opcode[1:0] == 2'b11 && addr[1:0] != 2'b00) ||
                       (opcode[1:0] == 2'b01 && addr[0]);
   assign memop      = valid_M & (is_load | is_store) & ~misaligned;
   assign exc_M      = (state == IDLE) & valid_M & (is_load | is_store) & misaligned;
   assign exc_code   = exc_M ? (is_store ? 5'd5 : 5'd4) : 5'd0;
`else
   assign memop    = valid_M & (is_load | is_store);
   assign exc_M    = 1'b0;
   assign exc_code = 5'd0;
`endif

   always_comb begin
      WD_M_sel = 2'd0;
      if (is_load)
         WD_M_sel = 2'd1;
      else if (opcode == 6'h03 || (opcode == 6'h00 && funct == 6'h09))
         WD_M_sel = 2'd2;
   end

   // opcode[1:0] distinguishes word (11), half (01) and byte (00) for every load/store
   always_comb begin
      case (opcode[1:0])
         2'b11: begin
            be_next    = 4'b1111;
            wdata_next = wdata;
         end
         2'b01: begin
            be_next    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{wdata[15:0]}};
         end
         default: begin
            be_next    = 4'b0001 << addr[1:0];
            wdata_next = {4{wdata[7:0]}};
         end
      endcase
   end

   assign byte_sel = bus_rdata[{lane, 3'b000} +: 8];
   assign half_sel = lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];

   always_comb begin
      case (ld_op)
         3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
         3'b100:  ld_ext = {24'd0, byte_sel};
         3'b101:  ld_ext = {16'd0, half_sel};
         default: ld_ext = bus_rdata;
      endcase
   end

   always_comb begin
      state_next = state;
      stall_M    = 1'b0;
      bus_req    = 1'b0;
      tmo_hit    = 1'b0;
      case (state)
         IDLE: begin
            stall_M = memop;
            if (memop) state_next = WAIT;
         end
         WAIT: begin
            bus_req = 1'b1;
            stall_M = 1'b1;
            if (bus_ack) begin
               state_next = DONE;
            end else if (cnt == CNT_LAST) begin
               state_next = DONE;
               tmo_hit    = 1'b1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Request attributes are frozen at issue so they stay stable while WAIT lasts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_addr    <= '0;
         bus_be      <= 4'd0;
         bus_we      <= 1'b0;
         bus_wdata   <= 32'd0;
         ld_op       <= 3'd0;
         lane        <= 2'd0;
         cnt         <= '0;
         ld_data     <= 32'd0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= tmo_hit;
         if (state == IDLE && memop) begin
            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            bus_be    <= be_next;
            bus_we    <= is_store;
            bus_wdata <= wdata_next;
            ld_op     <= opcode[2:0];
            lane      <= addr[1:0];
            cnt       <= '0;
         end
         if (state == WAIT) begin
            if (bus_ack) begin
               if (!bus_we) ld_data <= ld_ext;
            end else if (cnt == CNT_LAST) begin
               ld_data <= 32'd0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: loads/stores, lane steering, timeout, reset mid-access, writeback select.
module tb_mem_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = 32'd0;
   logic        valid_M = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic        bus_req, bus_we;
   logic [3:0]  bus_be;
   logic [31:0] bus_addr, bus_wdata;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = 32'd0;
   logic        stall_M, timeout_err, exc_M;
   logic [31:0] ld_data;
   logic [1:0]  WD_M_sel, fsm_state;
   logic [4:0]  exc_code;

   int errors = 0;
   int checks = 0;
   int waits;
   logic [3:0]  snap_be;
   logic [31:0] snap_addr, snap_wdata;
   logic        snap_we;

   localparam logic [31:0] OP_LW = 32'h8C00_0000, OP_LB = 32'h8000_0000, OP_LBU = 32'h9000_0000;
   localparam logic [31:0] OP_LH = 32'h8400_0000, OP_SB = 32'hA000_0000, OP_SW = 32'hAC00_0000;
   localparam logic [31:0] OP_JAL = 32'h0C00_0000, OP_ADDU = 32'h0000_0021, OP_JALR = 32'h0000_0009;

   mem_stage_ctrl dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .valid_M(valid_M), .addr(addr), .wdata(wdata),
      .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall_M(stall_M),
      .ld_data(ld_data), .WD_M_sel(WD_M_sel), .timeout_err(timeout_err), .exc_M(exc_M),
      .exc_code(exc_code), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issues one mem op; ack is raised in WAIT cycle number ack_at (negative = never).
   // Returns in the DONE cycle with the number of WAIT cycles seen and a snapshot of the request.
   task automatic run_mem(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int ack_at, output int n);
      @(negedge clk);
      instr = ins; valid_M = 1'b1; addr = a; wdata = wd;
      #1 chk("idle_stall", {31'd0, stall_M}, 32'd1);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (!bus_req) begin
            bus_ack = 1'b0;
            break;
         end
         if (n == 0) begin
            snap_be = bus_be; snap_addr = bus_addr; snap_wdata = bus_wdata; snap_we = bus_we;
         end
         bus_ack   = (n == ack_at);
         bus_rdata = rd;
         n++;
      end
      chk("done_no_stall", {31'd0, stall_M}, 32'd0);
   endtask

   task automatic go_idle();
      @(negedge clk);
      valid_M = 1'b0; bus_ack = 1'b0;
   endtask

   initial begin
      #1;
      chk("rst_req", {31'd0, bus_req}, 32'd0);
      chk("rst_we", {31'd0, bus_we}, 32'd0);
      chk("rst_be", {28'd0, bus_be}, 32'd0);
      chk("rst_ld", ld_data, 32'd0);
      chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
      chk("rst_state", {30'd0, fsm_state}, 32'd0);
      #20 rst_n = 1'b1;

      run_mem(OP_LW, 32'h10, 32'd0, 32'hDEADBEEF, 0, waits);
      chk("lw_waits", waits, 32'd1);
      chk("lw_data", ld_data, 32'hDEADBEEF);
      chk("lw_sel", {30'd0, WD_M_sel}, 32'd1);
      chk("lw_addr", snap_addr, 32'h10);
      chk("lw_be", {28'd0, snap_be}, 32'hF);
      chk("lw_we", {31'd0, snap_we}, 32'd0);
      chk("lw_state", {30'd0, fsm_state}, 32'd2);
      go_idle();

      run_mem(OP_LB, 32'h13, 32'd0, 32'h80112233, 0, waits);
      chk("lb_data", ld_data, 32'hFFFFFF80);
      go_idle();
      run_mem(OP_LBU, 32'h13, 32'd0, 32'h80112233, 0, waits);
      chk("lbu_data", ld_data, 32'h00000080);
      go_idle();
      run_mem(OP_LH, 32'h12, 32'd0, 32'h80112233, 0, waits);
      chk("lh_data", ld_data, 32'hFFFF8011);
      go_idle();
      run_mem(OP_LB, 32'h11, 32'd0, 32'h80112233, 2, waits);
      chk("lb1_waits", waits, 32'd3);
      chk("lb1_data", ld_data, 32'h00000022);
      go_idle();

      run_mem(OP_SB, 32'h21, 32'h000000A5, 32'h55555555, 0, waits);
      chk("sb_be", {28'd0, snap_be}, 32'h2);
      chk("sb_wdata", snap_wdata, 32'hA5A5A5A5);
      chk("sb_addr", snap_addr, 32'h20);
      chk("sb_we", {31'd0, snap_we}, 32'd1);
      chk("sb_ld_kept", ld_data, 32'h00000022);
      go_idle();

      run_mem(OP_LW, 32'h40, 32'd0, 32'h0BADF00D, -1, waits);
      chk("tmo_waits", waits, 32'd16);
      chk("tmo_pulse", {31'd0, timeout_err}, 32'd1);
      chk("tmo_ld", ld_data, 32'd0);
      go_idle();
      #1 chk("tmo_pulse_end", {31'd0, timeout_err}, 32'd0);

      run_mem(OP_LW, 32'h44, 32'd0, 32'h12345678, 15, waits);
      chk("lastack_waits", waits, 32'd16);
      chk("lastack_tmo", {31'd0, timeout_err}, 32'd0);
      chk("lastack_ld", ld_data, 32'h12345678);
      go_idle();

`ifdef ALIGN_EXC_EN
      @(negedge clk);
      instr = OP_SW; valid_M = 1'b1; addr = 32'h22; wdata = 32'hCAFEF00D;
      #1;
      chk("exc_flag", {31'd0, exc_M}, 32'd1);
      chk("exc_code", {27'd0, exc_code}, 32'd5);
      chk("exc_stall", {31'd0, stall_M}, 32'd0);
      @(negedge clk);
      #1 chk("exc_no_req", {31'd0, bus_req}, 32'd0);
      go_idle();
`else
      run_mem(OP_SW, 32'h22, 32'hCAFEF00D, 32'd0, 0, waits);
      chk("sw_mis_addr", snap_addr, 32'h20);
      chk("sw_mis_be", {28'd0, snap_be}, 32'hF);
      chk("sw_mis_wdata", snap_wdata, 32'hCAFEF00D);
      chk("sw_mis_exc", {31'd0, exc_M}, 32'd0);
      go_idle();
`endif

      @(negedge clk);
      instr = OP_LW; valid_M = 1'b1; addr = 32'h80;
      @(negedge clk);
      #1 chk("mid_wait_req", {31'd0, bus_req}, 32'd1);
      rst_n = 1'b0; valid_M = 1'b0;
      #1;
      chk("rst_mid_req", {31'd0, bus_req}, 32'd0);
      chk("rst_mid_state", {30'd0, fsm_state}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      instr = OP_ADDU; valid_M = 1'b1;
      #1;
      chk("addu_stall", {31'd0, stall_M}, 32'd0);
      chk("addu_sel", {30'd0, WD_M_sel}, 32'd0);
      @(negedge clk);
      instr = OP_JAL;
      #1;
      chk("jal_stall", {31'd0, stall_M}, 32'd0);
      chk("jal_sel", {30'd0, WD_M_sel}, 32'd2);
      @(negedge clk);
      instr = OP_JALR;
      #1;
      chk("jalr_sel", {30'd0, WD_M_sel}, 32'd2);
      chk("nonmem_state", {30'd0, fsm_state}, 32'd0);
      go_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench time limit exceeded");
   end

endmodule
